mt_thread_sched: RTL and testbench
==================================

Name: mt_thread_sched

Overview:
- Per-cycle thread selector for the barrel core; drives the `tid` consumed by the per-thread PC file and the fetch stage.
- Picks one ready hardware thread per cycle, round-robin among enabled, unblocked threads.
- Enforces a minimum re-issue gap per thread, so a thread never has two instructions in flight closer than the pipeline hazard window.
- Threads are enabled by a config write and blocked/unblocked by long-latency events (memory miss, fence).

Parameters:
- NUM_THREADS, 8, number of hardware threads (power of two, >=2).
- MIN_GAP, 4, minimum cycles between two issues of the same thread (1..NUM_THREADS; 1 = no restriction).
- THREAD_EN_RST, 1, reset value of the thread enable mask (NUM_THREADS bits; default enables thread 0 only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  pipeline stall; freezes all scheduler state, no issue.
- cfg_we  in  1  write thread enable mask.
- cfg_mask  in  NUM_THREADS  new enable mask.
- blk_set  in  1  block a thread.
- blk_set_tid  in  BITS_THREADS  thread to block.
- blk_clr  in  1  unblock a thread.
- blk_clr_tid  in  BITS_THREADS  thread to unblock.
- issue_valid  out  1  a thread is issued this cycle.
- issue_tid  out  BITS_THREADS  issued thread id (to PC file `tid`).
- thread_en  out  NUM_THREADS  current enable mask.
- thread_blk  out  NUM_THREADS  current block mask.
- BITS_THREADS = $clog2(NUM_THREADS), local.

Behaviour:
- State: en[NUM_THREADS], blk[NUM_THREADS], cnt[t] (width $clog2(MIN_GAP)+1), last_tid.
- Reset (async on rst_n low):
  - en=THREAD_EN_RST, blk=0, all cnt=0, last_tid=NUM_THREADS-1.
  - Hence after reset with defaults: issue_valid=1, issue_tid=0.
- ready[t] = en[t] & ~blk[t] & (cnt[t]==0).
- Selection is combinational from registered state (zero latency):
  - Search t = last_tid+1, last_tid+2, ... modulo NUM_THREADS (wraps).
  - The first ready thread is issued.
  - If none is ready: issue_valid=0, issue_tid=last_tid.
  - If stall=1: issue_valid=0, issue_tid=last_tid.
- Clock edge with issue (issue_valid=1):
  - last_tid <= issue_tid.
  - cnt[issue_tid] <= MIN_GAP-1.
  - Every other cnt!=0 decrements by 1.
- Clock edge without issue and stall=0: all nonzero cnt decrement; last_tid holds.
- stall=1: last_tid and all cnt hold; en/blk updates still apply.
- cfg_we: en <= cfg_mask at the edge. The current cycle's selection uses the old mask. Disabling a thread does not clear its blk or cnt.
- blk_set: blk[blk_set_tid] <= 1. blk_clr: blk[blk_clr_tid] <= 0.
- Same tid set and clr in the same cycle: clr wins (blk=0).
- blk_set on the thread being issued this cycle: that issue proceeds; the block applies from the next cycle.
- All threads disabled or blocked: issue_valid=0 indefinitely, no error.
- MIN_GAP=1: a single ready thread issues every cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; outputs follow combinationally.

Optional Feature:
- Macro: MT_SCHED_PRIO_EN.
- Defined:
  - Adds ports cfg_prio_we (in, 1) and cfg_prio_tid (in, BITS_THREADS), plus register prio_tid (reset 0) and prio_on (reset 0).
  - cfg_prio_we sets prio_tid and sets prio_on=1.
  - When prio_on and ready[prio_tid], prio_tid is issued regardless of round-robin order; last_tid and cnt update as normal.
  - MIN_GAP still bounds the priority thread, so other threads fill its gap cycles.
- Undefined: ports and registers are absent; pure round-robin.

Test Plan:
- Reset defaults, stall=0, no config -> issue_tid=0 at cycles 0,4,8,... with issue_valid=1; issue_valid=0 at cycles 1-3, 5-7 (MIN_GAP=4).
- cfg_mask=8'hFF, no blocks -> issue_tid sequence 1,2,3,4,5,6,7,0,1,... with issue_valid=1 every cycle; no tid repeats within 4 cycles.
- Mask 8'hFF, blk_set tid=3 while rotation is at tid 2 -> tid 3 skipped (2,4,5,...); blk_clr tid=3 -> tid 3 re-enters at its next round-robin turn.
- Mask 8'h05, stall held high 3 cycles after issuing tid 0 -> issue_valid=0 for those 3 cycles; on release the next issue is tid 2 and tid 0's cnt resumes from its frozen value.
- blk_set and blk_clr both on tid 5 in the same cycle with blk[5]=1 -> thread_blk[5]=0 next cycle; blk_set on the currently issued tid -> that issue completes and thread_blk bit is 1 next cycle.
- rst_n pulsed low asynchronously mid-stream with mask 8'hFF -> thread_en=THREAD_EN_RST and thread_blk=0 immediately; first issue after release is tid 0.

Source files
------------

// File: rtl/mt_thread_sched.sv
// Round-robin barrel-core thread selector with a per-thread minimum re-issue gap.
// Define MT_SCHED_PRIO_EN to add a configurable priority thread that overrides round-robin order.
module mt_thread_sched #(
  parameter int                     NUM_THREADS   = 8,
  parameter int                     MIN_GAP       = 4,
  parameter logic [NUM_THREADS-1:0] THREAD_EN_RST = {{(NUM_THREADS-1){1'b0}}, 1'b1},
  localparam int                    BITS_THREADS  = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    cfg_we,
  input  logic [NUM_THREADS-1:0]  cfg_mask,
  input  logic                    blk_set,
  input  logic [BITS_THREADS-1:0] blk_set_tid,
  input  logic                    blk_clr,
  input  logic [BITS_THREADS-1:0] blk_clr_tid,
`ifdef MT_SCHED_PRIO_EN
  input  logic                    cfg_prio_we,
  input  logic [BITS_THREADS-1:0] cfg_prio_tid,
`endif
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] issue_tid,
  output logic [NUM_THREADS-1:0]  thread_en,
  output logic [NUM_THREADS-1:0]  thread_blk
);

  localparam int                 CW     = $clog2(MIN_GAP) + 1;
  localparam logic [CW-1:0]      GAP_LD = CW'(MIN_GAP - 1);

  logic [NUM_THREADS-1:0]  en;
  logic [NUM_THREADS-1:0]  blk;
  logic [NUM_THREADS-1:0]  blk_nxt;
  logic [NUM_THREADS-1:0]  ready;
  logic [CW-1:0]           cnt [NUM_THREADS];
  logic [BITS_THREADS-1:0] last_tid;
  logic                    rr_found;
  logic [BITS_THREADS-1:0] rr_tid;
  logic                    sel_valid;
  logic [BITS_THREADS-1:0] sel_tid;

`ifdef MT_SCHED_PRIO_EN
  logic [BITS_THREADS-1:0] prio_tid;
  logic                    prio_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_tid <= '0;
      prio_on  <= 1'b0;
    end else if (cfg_prio_we) begin
      prio_tid <= cfg_prio_tid;
      prio_on  <= 1'b1;
    end
  end
`endif

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++)
      ready[t] = en[t] & ~blk[t] & (cnt[t] == '0);
  end

  // Search starts one past the last issued thread; the index wraps naturally
  // because NUM_THREADS is a power of two, so last_tid itself is tried last.
  always_comb begin
    rr_found = 1'b0;
    rr_tid   = last_tid;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      if (!rr_found && ready[last_tid + BITS_THREADS'(i)]) begin
        rr_found = 1'b1;
        rr_tid   = last_tid + BITS_THREADS'(i);
      end
    end
  end

  always_comb begin
    sel_valid = rr_found;
    sel_tid   = rr_tid;
`ifdef MT_SCHED_PRIO_EN
    if (prio_on && ready[prio_tid]) begin
      sel_valid = 1'b1;
      sel_tid   = prio_tid;
    end
`endif
    issue_valid = sel_valid & ~stall;
    issue_tid   = issue_valid ? sel_tid : last_tid;
  end

  // Clear is applied after set so it wins when both target the same thread.
  always_comb begin
    blk_nxt = blk;
    if (blk_set) blk_nxt[blk_set_tid] = 1'b1;
    if (blk_clr) blk_nxt[blk_clr_tid] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= THREAD_EN_RST;
      blk <= '0;
    end else begin
      if (cfg_we) en <= cfg_mask;
      blk <= blk_nxt;
    end
  end

  // Gap counters and rotation pointer freeze entirely during stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_tid <= BITS_THREADS'(NUM_THREADS - 1);
      for (int t = 0; t < NUM_THREADS; t++) cnt[t] <= '0;
    end else if (!stall) begin
      if (issue_valid) last_tid <= issue_tid;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (issue_valid && (issue_tid == BITS_THREADS'(t)))
          cnt[t] <= GAP_LD;
        else if (cnt[t] != '0)
          cnt[t] <= cnt[t] - CW'(1);
      end
    end
  end

  assign thread_en  = en;
  assign thread_blk = blk;

endmodule

// File: tb/tb_mt_thread_sched.sv
// Directed table-driven bench for mt_thread_sched with default parameters (8 threads, MIN_GAP 4).
module tb_mt_thread_sched;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       cfg_we;
  logic [7:0] cfg_mask;
  logic       blk_set;
  logic [2:0] blk_set_tid;
  logic       blk_clr;
  logic [2:0] blk_clr_tid;
  logic       issue_valid;
  logic [2:0] issue_tid;
  logic [7:0] thread_en;
  logic [7:0] thread_blk;

  int n_chk;
  int n_fail;

  mt_thread_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .cfg_we      (cfg_we),
    .cfg_mask    (cfg_mask),
    .blk_set     (blk_set),
    .blk_set_tid (blk_set_tid),
    .blk_clr     (blk_clr),
    .blk_clr_tid (blk_clr_tid),
`ifdef MT_SCHED_PRIO_EN
    .cfg_prio_we (1'b0),
    .cfg_prio_tid(3'd0),
`endif
    .issue_valid (issue_valid),
    .issue_tid   (issue_tid),
    .thread_en   (thread_en),
    .thread_blk  (thread_blk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       we;
    logic [7:0] mask;
    logic       bs;
    logic [2:0] bst;
    logic       bc;
    logic [2:0] bct;
    logic       ev;
    logic [2:0] etid;
    logic [7:0] een;
    logic [7:0] eblk;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(logic s, logic we, logic [7:0] m, logic bs, logic [2:0] bst,
                              logic bc, logic [2:0] bct, logic ev, logic [2:0] etid,
                              logic [7:0] een, logic [7:0] eblk);
    vec_t v;
    v.stall = s; v.we = we; v.mask = m; v.bs = bs; v.bst = bst; v.bc = bc; v.bct = bct;
    v.ev = ev; v.etid = etid; v.een = een; v.eblk = eblk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [2:0] etid,
                           input logic [7:0] een, input logic [7:0] eblk);
    chk({nm, " issue_valid"}, 32'(issue_valid), 32'(ev));
    chk({nm, " issue_tid"},   32'(issue_tid),   32'(etid));
    chk({nm, " thread_en"},   32'(thread_en),   32'(een));
    chk({nm, " thread_blk"},  32'(thread_blk),  32'(eblk));
  endtask

  // Called at a falling edge: drive, check combinational outputs, cross the rising edge.
  task automatic cyc(input string nm, input vec_t v);
    stall = v.stall; cfg_we = v.we; cfg_mask = v.mask;
    blk_set = v.bs; blk_set_tid = v.bst; blk_clr = v.bc; blk_clr_tid = v.bct;
    #1;
    check_out(nm, v.ev, v.etid, v.een, v.eblk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; cfg_we = 1'b0; cfg_mask = 8'h00;
    blk_set = 1'b0; blk_set_tid = 3'd0; blk_clr = 1'b0; blk_clr_tid = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //           st we mask  bs bst bc bct  ev tid  en     blk
    vt[0]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 0, 8'h01, 8'h00);
    vt[1]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   0, 0, 8'h01, 8'h00);
    vt[2]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   0, 0, 8'h01, 8'h00);
    vt[3]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   0, 0, 8'h01, 8'h00);
    vt[4]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 0, 8'h01, 8'h00);
    vt[5]  = mk(0, 1, 8'hFF, 0, 0, 0, 0,   0, 0, 8'h01, 8'h00);
    vt[6]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 1, 8'hFF, 8'h00);
    vt[7]  = mk(0, 0, 8'h00, 1, 3, 0, 0,   1, 2, 8'hFF, 8'h00);
    vt[8]  = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 4, 8'hFF, 8'h08);
    vt[9]  = mk(0, 0, 8'h00, 0, 0, 1, 3,   1, 5, 8'hFF, 8'h08);
    vt[10] = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 6, 8'hFF, 8'h00);
    vt[11] = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 7, 8'hFF, 8'h00);
    vt[12] = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 0, 8'hFF, 8'h00);
    vt[13] = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 1, 8'hFF, 8'h00);
    vt[14] = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 2, 8'hFF, 8'h00);
    vt[15] = mk(0, 0, 8'h00, 0, 0, 0, 0,   1, 3, 8'hFF, 8'h00);
    vt[16] = mk(0, 0, 8'h00, 1, 4, 0, 0,   1, 4, 8'hFF, 8'h00);
    vt[17] = mk(0, 0, 8'h00, 1, 5, 0, 0,   1, 5, 8'hFF, 8'h10);
    vt[18] = mk(0, 0, 8'h00, 1, 5, 1, 5,   1, 6, 8'hFF, 8'h30);
    vt[19] = mk(0, 0, 8'h00, 0, 0, 1, 4,   1, 7, 8'hFF, 8'h10);
    vt[20] = mk(0, 0, 8'h00, 1, 1, 0, 0,   1, 0, 8'hFF, 8'h00);

    do_reset();
    for (int i = 0; i < 21; i++) cyc($sformatf("vec%0d", i), vt[i]);

    // Asynchronous reset mid-cycle with mask FF and thread 1 blocked.
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 1'b1, 3'd0, 8'h01, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst_issue", mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 8'h01, 8'h00));
    cyc("all_dis_a",      mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    cyc("all_dis_b",      mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    cyc("all_dis_c",      mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));

    // Stall freezes thread 0's gap counter; tid 0 returns only after the full gap.
    do_reset();
    cyc("stall_issue0", mk(0, 1, 8'h05, 0, 0, 0, 0, 1, 0, 8'h01, 8'h00));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("stall%0d", i), mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h05, 8'h00));
    cyc("stall_rel_t2",  mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h05, 8'h00));
    cyc("stall_gap_a",   mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 8'h05, 8'h00));
    cyc("stall_gap_b",   mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 8'h05, 8'h00));
    cyc("stall_t0_back", mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h05, 8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
